// File: rtl/lcd_power_seq.sv
// lcd_power_seq: LCD panel power-up/power-down sequencer with frame-aligned sync enable/disable
// Ports: clk_lcd (clock), rst_n (async active-low reset), pwr_req (1 = panel wanted on),
//        frame_end (end-of-frame pulse), avdd (analog supply enable), lcd_rst (panel reset),
//        en_sync (sync generator enable), en (pixel data enable), pwr_ack (fully on),
//        busy (sequencing in progress), timeout_err (sticky frame_end wait timeout)
module lcd_power_seq #(
    parameter int CNT_W    = 16,
    parameter int T_AVDD   = 1000,
    parameter int T_RST    = 200,
    parameter int T_OFF    = 500,
    parameter int FRAME_TO = 60000
) (
    input  logic clk_lcd,
    input  logic rst_n,
    input  logic pwr_req,
    input  logic frame_end,
    output logic avdd,
    output logic lcd_rst,
    output logic en_sync,
    output logic en,
    output logic pwr_ack,
    output logic busy,
    output logic timeout_err
);
    typedef enum logic [2:0] {OFF, AVDD_UP, RST_REL, SYNC_ON, ON, DRAIN, PWR_DOWN} state_t;
    // Reload values are T-1 so a timed state lasts exactly T cycles; 0 behaves as 1
    localparam logic [CNT_W-1:0] LD_AVDD = CNT_W'((T_AVDD > 1) ? T_AVDD - 1 : 0);
    localparam logic [CNT_W-1:0] LD_RST  = CNT_W'((T_RST > 1) ? T_RST - 1 : 0);
    localparam logic [CNT_W-1:0] LD_OFF  = CNT_W'((T_OFF > 1) ? T_OFF - 1 : 0);
    localparam logic [CNT_W-1:0] LD_TO   = CNT_W'((FRAME_TO > 1) ? FRAME_TO - 1 : 0);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             armed_q;
    logic             expired;
    // armed_q holds off any transition on the first edge after reset release
    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            armed_q <= 1'b1;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        err_d   = err_q;
        expired = cnt_q == '0;
        if (armed_q) begin
            case (state_q)
                OFF: if (pwr_req) begin
                    state_d = AVDD_UP;
                    cnt_d   = LD_AVDD;
                    err_d   = 1'b0;
                end
                AVDD_UP: if (!pwr_req) begin
                    state_d = PWR_DOWN;
                    cnt_d   = LD_OFF;
                end else if (expired) begin
                    state_d = RST_REL;
                    cnt_d   = LD_RST;
                end
                RST_REL: if (!pwr_req) begin
                    state_d = PWR_DOWN;
                    cnt_d   = LD_OFF;
                end else if (expired) begin
                    state_d = SYNC_ON;
                    cnt_d   = LD_TO;
                end
                // shutdown outranks a same-cycle frame_end or timeout
                SYNC_ON: if (!pwr_req) begin
                    state_d = DRAIN;
                    cnt_d   = LD_TO;
                end else if (frame_end) begin
                    state_d = ON;
                end else if (expired) begin
                    state_d = ON;
                    err_d   = 1'b1;
                end
                ON: if (!pwr_req) begin
                    state_d = DRAIN;
                    cnt_d   = LD_TO;
                end
                DRAIN: if (frame_end || expired) begin
                    state_d = PWR_DOWN;
                    cnt_d   = LD_OFF;
                    err_d   = err_q | !frame_end;
                end
                PWR_DOWN: if (expired) state_d = OFF;
                default: state_d = OFF;
            endcase
        end
    end
    always_comb begin
        avdd        = state_q != OFF;
        lcd_rst     = state_q == OFF || state_q == AVDD_UP;
        en_sync     = state_q == SYNC_ON || state_q == ON || state_q == DRAIN;
        en          = state_q == ON;
        pwr_ack     = state_q == ON;
        busy        = state_q != OFF && state_q != ON;
        timeout_err = err_q;
    end
endmodule

// File: doc/lcd_power_seq.md
LCD_POWER_SEQ -- requirements
Module: lcd_power_seq

Interface
REQ-001 Parameter CNT_W, default 16: width of the delay/timeout counter.
REQ-002 Parameter T_AVDD, default 1000: cycles spent in AVDD_UP.
REQ-003 Parameter T_RST, default 200: cycles spent in RST_REL.
REQ-004 Parameter T_OFF, default 500: cycles spent in PWR_DOWN.
REQ-005 Parameter FRAME_TO, default 60000: max cycles to wait for frame_end in SYNC_ON/DRAIN.
REQ-006 All timing parameters SHALL be < 2^CNT_W; a value of 0 SHALL behave as 1.
REQ-007 clk_lcd  in  1  single clock; all state and outputs sample its rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 pwr_req  in  1  level; 1 = panel wanted on, 0 = panel wanted off.
REQ-010 frame_end  in  1  one-cycle pulse from the timing generator at end of frame.
REQ-011 avdd  out  1  panel analog supply enable.
REQ-012 lcd_rst  out  1  panel reset, active high.
REQ-013 en_sync  out  1  sync generator enable.
REQ-014 en  out  1  pixel data enable.
REQ-015 pwr_ack  out  1  1 only while fully on (state ON).
REQ-016 busy  out  1  1 in every state except OFF and ON.
REQ-017 timeout_err  out  1  sticky: a frame_end wait timed out.

Function
REQ-018 States SHALL be OFF, AVDD_UP, RST_REL, SYNC_ON, ON, DRAIN, PWR_DOWN; outputs Moore-decoded from the state register only.
REQ-019 Outputs per state (avdd,lcd_rst,en_sync,en): OFF 0,1,0,0; AVDD_UP 1,1,0,0; RST_REL 1,0,0,0; SYNC_ON 1,0,1,0; ON 1,0,1,1; DRAIN 1,0,1,0; PWR_DOWN 1,0,0,0.
REQ-020 Counter SHALL load (T-1) on entry to a timed state and decrement each cycle; expiry = count 0, so a timed state lasts exactly T cycles.
REQ-021 OFF -> AVDD_UP when pwr_req=1; entering AVDD_UP clears timeout_err.
REQ-022 AVDD_UP -> RST_REL on expiry; RST_REL -> SYNC_ON on expiry.
REQ-023 SYNC_ON -> ON on frame_end; if FRAME_TO cycles pass with no frame_end, set timeout_err and -> ON.
REQ-024 ON -> DRAIN when pwr_req=0.
REQ-025 DRAIN -> PWR_DOWN on frame_end, or on FRAME_TO expiry with timeout_err set.
REQ-026 PWR_DOWN -> OFF on expiry.
REQ-027 pwr_req=0 in AVDD_UP or RST_REL SHALL abort directly to PWR_DOWN (full T_OFF), regardless of counter state.
REQ-028 pwr_req=0 in SYNC_ON SHALL go to DRAIN; shutdown has priority over a same-cycle frame_end or timeout.
REQ-029 pwr_req=1 during DRAIN or PWR_DOWN SHALL NOT abort shutdown; the sequence completes to OFF, spends at least one cycle there, then restarts.
REQ-030 frame_end SHALL be ignored in every state other than SYNC_ON and DRAIN.
REQ-031 en SHALL never be 1 while lcd_rst=1 or avdd=0; avdd SHALL never fall while en_sync=1.

Reset
REQ-032 rst_n=0 SHALL immediately force state OFF, counter 0, avdd=0, lcd_rst=1, en_sync=0, en=0, pwr_ack=0, busy=0, timeout_err=0.
REQ-033 Reset asserted mid-sequence (any state) SHALL give the same values with no intermediate output states.
REQ-034 After rst_n rises, the first transition SHALL occur no earlier than the second rising edge of clk_lcd.

Verification (T_AVDD=4, T_RST=3, T_OFF=5, FRAME_TO=10)
REQ-035 Power-up: pwr_req=1 held, frame_end 2 cycles after SYNC_ON entry -> AVDD_UP 4 cycles, RST_REL 3 cycles, SYNC_ON 2 cycles, then pwr_ack=1, en=1.
REQ-036 Power-down: pwr_req=0 in ON, frame_end 5 cycles later -> DRAIN 5 cycles (en=0, en_sync=1), PWR_DOWN 5 cycles, OFF with avdd=0.
REQ-037 Timeout: SYNC_ON with no frame_end -> ON after exactly 10 cycles, timeout_err=1; it stays 1 through OFF and clears on the next AVDD_UP entry.
REQ-038 Abort: pwr_req drops in cycle 2 of RST_REL -> PWR_DOWN next cycle; en_sync and en stay 0; OFF after 5 cycles.
REQ-039 Re-request: pwr_req back to 1 in PWR_DOWN cycle 1 -> PWR_DOWN completes 5 cycles, 1 cycle OFF, then AVDD_UP.
REQ-040 Async reset: rst_n=0 mid-ON between clock edges -> avdd=0, lcd_rst=1, en=0 before the next clk_lcd edge.
